// File: rtl/interval_timer_ctrl.sv
// Start/stop control for a free-running up_counter: turns the raw count into
// one-shot or periodic interval events (tick/busy/done) and drives the counter clear.
module interval_timer_ctrl #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             mode,
   input  logic [CNT_W-1:0] terminal,
   input  logic [CNT_W-1:0] q,
   output logic             sclr,
   output logic             tick,
   output logic             busy,
   output logic             done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CNT_W-1:0] tc_reg;
   logic             mode_reg;
   logic             running;
   logic             match;

   assign running = (state == RUN);
   // >= rather than == so an overshooting count still ends the interval
   assign match   = (q >= tc_reg);
   assign sclr    = rst | ~running | match | stop;
   assign busy    = running;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tc_reg   <= '0;
         mode_reg <= 1'b0;
         tick     <= 1'b0;
         done     <= 1'b0;
      end else begin
         tick <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !stop) begin
                  tc_reg   <= terminal;
                  mode_reg <= mode;
                  done     <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               // stop wins over a match on the same cycle: no tick, done untouched
               if (stop) begin
                  state <= IDLE;
               end else if (match) begin
                  tick <= 1'b1;
                  if (!mode_reg) begin
                     state <= IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
